// File: rtl/port_comparator.sv
// port_comparator
// Watches 32-bit frame words from the input FIFO and checks for Ethernet/IPv4
// TCP or UDP frames. It raises a sticky port_match when the destination port
// (word 9 [31:16]) equals the configured port.
// Build option: define PORT_CMP_SRC_EN to also match the source port
// (word 8 [15:0]). Either port hitting then sets port_match after word 9.
module port_comparator (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_in,
  input  logic        data_valid,
  input  logic        sop,
  input  logic        eop,
  input  logic [15:0] port_cfg,
  input  logic        cfg_load,
  input  logic        clear,
  output logic        port_match,
  output logic        verdict_valid,
  output logic        short_frame
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HEADER = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  state_t      r_state;
  // Index of the most recently accepted word of the current frame (sop word = 0).
  logic [3:0]  r_idx;
  logic [15:0] r_cfg;
  logic        r_cfg_valid;
  logic [15:0] r_snap_cfg;
  logic        r_snap_valid;
  logic        r_eth_ok;
  logic        r_l4_ok;
  logic        r_match;
  logic        r_verdict;
  logic        r_short;
`ifdef PORT_CMP_SRC_EN
  logic        r_src_hit;
`endif

  logic        w_accept;
  logic [3:0]  w_cur_idx;
  logic        w_eth_ok;
  logic        w_l4_ok;
  logic        w_dst_hit;
  logic        w_port_hit;
  logic        w_set;

  // Decode the word currently on the bus: its index and per-field checks
  always_comb begin
    w_accept = data_valid && (sop || (r_state != IDLE));

    if (sop) begin
      w_cur_idx = '0;
    end else if (r_idx == 4'd10) begin
      w_cur_idx = 4'd10;
    end else begin
      w_cur_idx = r_idx + 4'd1;
    end

    w_eth_ok  = (data_in[31:16] == 16'h0800) &&
                (data_in[15:12] == 4'd4) &&
                (data_in[11:8]  == 4'd5);
    w_l4_ok   = (data_in[7:0] == 8'd6) || (data_in[7:0] == 8'd17);
    w_dst_hit = (data_in[31:16] == r_snap_cfg);
`ifdef PORT_CMP_SRC_EN
    w_port_hit = w_dst_hit || r_src_hit;
`else
    w_port_hit = w_dst_hit;
`endif

    w_set = data_valid && !sop && (r_state == HEADER) && (w_cur_idx == 4'd9) &&
            r_eth_ok && r_l4_ok && r_snap_valid && w_port_hit;
  end

  // Frame-tracking FSM: word index, per-frame snapshot, eligibility, verdict pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_idx        <= '0;
      r_snap_cfg   <= '0;
      r_snap_valid <= 1'b0;
      r_eth_ok     <= 1'b0;
      r_l4_ok      <= 1'b0;
      r_verdict    <= 1'b0;
      r_short      <= 1'b0;
`ifdef PORT_CMP_SRC_EN
      r_src_hit    <= 1'b0;
`endif
    end else begin
      r_verdict <= 1'b0;
      r_short   <= 1'b0;
      if (w_accept) begin
        r_idx <= w_cur_idx;
        if (sop) begin
          r_snap_cfg   <= r_cfg;
          r_snap_valid <= r_cfg_valid;
          r_eth_ok     <= 1'b0;
          r_l4_ok      <= 1'b0;
`ifdef PORT_CMP_SRC_EN
          r_src_hit    <= 1'b0;
`endif
        end
        if (w_cur_idx == 4'd3) begin
          r_eth_ok <= w_eth_ok;
        end
        if (w_cur_idx == 4'd5) begin
          r_l4_ok <= w_l4_ok;
        end
`ifdef PORT_CMP_SRC_EN
        if (w_cur_idx == 4'd8) begin
          r_src_hit <= (data_in[15:0] == r_snap_cfg);
        end
`endif
        if (eop) begin
          r_state   <= IDLE;
          r_verdict <= 1'b1;
          r_short   <= (w_cur_idx < 4'd9);
        end else if (w_cur_idx >= 4'd9) begin
          r_state <= DRAIN;
        end else begin
          r_state <= HEADER;
        end
      end
    end
  end

  // Configuration register, loadable on any cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cfg       <= '0;
      r_cfg_valid <= 1'b0;
    end else if (cfg_load) begin
      r_cfg       <= port_cfg;
      r_cfg_valid <= 1'b1;
    end
  end

  // Sticky match flag; a set in the same cycle beats clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_match <= 1'b0;
    end else if (w_set) begin
      r_match <= 1'b1;
    end else if (clear) begin
      r_match <= 1'b0;
    end
  end

  assign port_match    = r_match;
  assign verdict_valid = r_verdict;
  assign short_frame   = r_short;

endmodule
